dm9000a_bus_arbiter: RTL and testbench

- Shares the single DM9000A host bus between NUM_REQ requesters: init sequencer, TX packet loader, interrupt service.
- Each request is one register access: an index cycle (CMD=0, address) followed by a data cycle (CMD=1, write or read).
- A data-only variant skips the index cycle, for F8/F0 memory-port bursts.
- Round-robin arbitration with a per-requester lock so a multi-access sequence (e.g. F8 then packet words) is not interleaved.

---
 rtl/dm9000a_bus_arbiter.sv | 252 +++++++++++++++++++++++++
 tb/tb_dm9000a_bus_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm9000a_bus_arbiter.sv
// Round-robin arbiter sharing the DM9000A host bus between NUM_REQ requesters.
// Each grant runs one index+data (or data-only) register access with fixed bus timing.
module dm9000a_bus_arbiter #(
  parameter int unsigned NUM_REQ   = 3,
  parameter int unsigned SETUP_CYC = 1,
  parameter int unsigned PULSE_CYC = 2,
  parameter int unsigned RECOV_CYC = 2
) (
  input  logic                    clk50,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ-1:0]      req_lock,
  input  logic [NUM_REQ-1:0]      req_we,
  input  logic [NUM_REQ-1:0]      req_data_only,
  input  logic [8*NUM_REQ-1:0]    req_addr,
  input  logic [16*NUM_REQ-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]      grant,
  output logic [NUM_REQ-1:0]      ack,
  output logic [15:0]             rdata,
  output logic                    busy,
  output logic [15:0]             enet_data_out,
  output logic                    enet_data_oe,
  input  logic [15:0]             enet_data_in,
  output logic                    enet_cmd,
  output logic                    enet_cs_n,
  output logic                    enet_rd_n,
  output logic                    enet_wr_n
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CntW = 8;

  localparam logic [CntW-1:0] SetupLd = CntW'(SETUP_CYC - 1);
  localparam logic [CntW-1:0] PulseLd = CntW'(PULSE_CYC - 1);
  localparam logic [CntW-1:0] RecovLd = CntW'(RECOV_CYC - 1);

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StIdxSetup = 3'd1;
  localparam logic [2:0] StIdxPulse = 3'd2;
  localparam logic [2:0] StIdxRecov = 3'd3;
  localparam logic [2:0] StDatSetup = 3'd4;
  localparam logic [2:0] StDatPulse = 3'd5;
  localparam logic [2:0] StDatRecov = 3'd6;
  localparam logic [2:0] StDone     = 3'd7;

  logic [2:0]         state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [IdxW-1:0]    ptr_q, ptr_d;
  logic [IdxW-1:0]    owner_q, owner_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [7:0]         addr_q, addr_d;
  logic [15:0]        wdata_q, wdata_d;
  logic               we_q, we_d;
  logic               data_only_q, data_only_d;
  logic [15:0]        rdata_q, rdata_d;

  logic               win_valid;
  logic [IdxW-1:0]    win_idx;
  logic [IdxW-1:0]    cand;
  int unsigned        sum;

  logic               load_en;
  logic [IdxW-1:0]    load_idx;

  // First set request at or after the pointer, wrapping modulo NUM_REQ.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    cand      = '0;
    sum       = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      sum = 32'(ptr_q) + k;
      if (sum >= NUM_REQ) begin
        sum = sum - NUM_REQ;
      end
      cand = IdxW'(sum);
      if (!win_valid && req[cand]) begin
        win_valid = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    grant_d     = grant_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    data_only_d = data_only_q;
    rdata_d     = rdata_q;
    load_en     = 1'b0;
    load_idx    = '0;

    case (state_q)
      StIdle: begin
        if (win_valid) begin
          load_en  = 1'b1;
          load_idx = win_idx;
          owner_d  = win_idx;
          grant_d  = '0;
          grant_d[win_idx] = 1'b1;
          if (32'(win_idx) == NUM_REQ - 1) begin
            ptr_d = '0;
          end else begin
            ptr_d = win_idx + 1'b1;
          end
          state_d = req_data_only[win_idx] ? StDatSetup : StIdxSetup;
          cnt_d   = SetupLd;
        end
      end

      StIdxSetup: begin
        if (cnt_q == '0) begin
          state_d = StIdxPulse;
          cnt_d   = PulseLd;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      StIdxPulse: begin
        if (cnt_q == '0) begin
          state_d = StIdxRecov;
          cnt_d   = RecovLd;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      StIdxRecov: begin
        if (cnt_q == '0) begin
          state_d = StDatSetup;
          cnt_d   = SetupLd;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      StDatSetup: begin
        if (cnt_q == '0) begin
          state_d = StDatPulse;
          cnt_d   = PulseLd;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      StDatPulse: begin
        if (cnt_q == '0) begin
          // Sample read data on the last strobe-low cycle.
          if (!we_q) begin
            rdata_d = enet_data_in;
          end
          state_d = StDatRecov;
          cnt_d   = RecovLd;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      StDatRecov: begin
        if (cnt_q == '0) begin
          state_d = StDone;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      StDone: begin
        // A locked owner still requesting chains straight into its next access.
        if (req_lock[owner_q] && req[owner_q]) begin
          load_en  = 1'b1;
          load_idx = owner_q;
          state_d  = req_data_only[owner_q] ? StDatSetup : StIdxSetup;
          cnt_d    = SetupLd;
        end else begin
          grant_d = '0;
          state_d = StIdle;
        end
      end

      default: begin
        grant_d = '0;
        state_d = StIdle;
      end
    endcase

    if (load_en) begin
      addr_d      = req_addr[{load_idx, 3'b000} +: 8];
      wdata_d     = req_wdata[{load_idx, 4'b0000} +: 16];
      we_d        = req_we[load_idx];
      data_only_d = req_data_only[load_idx];
    end
  end

  always_ff @(posedge clk50) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      ptr_q       <= '0;
      owner_q     <= '0;
      grant_q     <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      data_only_q <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      grant_q     <= grant_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      data_only_q <= data_only_d;
      rdata_q     <= rdata_d;
    end
  end

  logic in_idx;
  logic in_dat;

  // Bus pins decode from registered state only, so no input reaches them combinationally.
  always_comb begin
    in_idx = (state_q == StIdxSetup) || (state_q == StIdxPulse) || (state_q == StIdxRecov);
    in_dat = (state_q == StDatSetup) || (state_q == StDatPulse) || (state_q == StDatRecov);

    grant         = grant_q;
    ack           = (state_q == StDone) ? grant_q : '0;
    rdata         = rdata_q;
    busy          = (state_q != StIdle);
    enet_cs_n     = !(in_idx || in_dat);
    enet_cmd      = in_dat;
    enet_data_oe  = in_idx || (in_dat && we_q);
    enet_wr_n     = !((state_q == StIdxPulse) || ((state_q == StDatPulse) && we_q));
    enet_rd_n     = !((state_q == StDatPulse) && !we_q);
    enet_data_out = '0;
    if (in_idx) begin
      enet_data_out = {8'h00, addr_q};
    end else if (in_dat && we_q) begin
      enet_data_out = wdata_q;
    end
  end

endmodule

// File: tb/tb_dm9000a_bus_arbiter.sv
// Directed bench for dm9000a_bus_arbiter: timing, read capture, round-robin, lock chains,
// mid-access reset and a non-default timing instance.
module tb_dm9000a_bus_arbiter;

  logic        clk50;
  logic        reset;
  logic [2:0]  req, req_lock, req_we, req_data_only;
  logic [23:0] req_addr;
  logic [47:0] req_wdata;
  logic [2:0]  grant, ack;
  logic [15:0] rdata;
  logic        busy;
  logic [15:0] enet_data_out;
  logic        enet_data_oe;
  logic [15:0] enet_data_in;
  logic        enet_cmd, enet_cs_n, enet_rd_n, enet_wr_n;

  logic [2:0]  p_req, p_req_lock, p_req_we, p_req_data_only;
  logic [23:0] p_req_addr;
  logic [47:0] p_req_wdata;
  logic [2:0]  p_grant, p_ack;
  logic [15:0] p_rdata;
  logic        p_busy;
  logic [15:0] p_data_out;
  logic        p_data_oe;
  logic        p_cmd, p_cs_n, p_rd_n, p_wr_n;

  int errors = 0;
  int checks = 0;

  dm9000a_bus_arbiter dut (
    .clk50         (clk50),
    .reset         (reset),
    .req           (req),
    .req_lock      (req_lock),
    .req_we        (req_we),
    .req_data_only (req_data_only),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .grant         (grant),
    .ack           (ack),
    .rdata         (rdata),
    .busy          (busy),
    .enet_data_out (enet_data_out),
    .enet_data_oe  (enet_data_oe),
    .enet_data_in  (enet_data_in),
    .enet_cmd      (enet_cmd),
    .enet_cs_n     (enet_cs_n),
    .enet_rd_n     (enet_rd_n),
    .enet_wr_n     (enet_wr_n)
  );

  dm9000a_bus_arbiter #(
    .NUM_REQ   (3),
    .SETUP_CYC (2),
    .PULSE_CYC (3),
    .RECOV_CYC (1)
  ) dut_p (
    .clk50         (clk50),
    .reset         (reset),
    .req           (p_req),
    .req_lock      (p_req_lock),
    .req_we        (p_req_we),
    .req_data_only (p_req_data_only),
    .req_addr      (p_req_addr),
    .req_wdata     (p_req_wdata),
    .grant         (p_grant),
    .ack           (p_ack),
    .rdata         (p_rdata),
    .busy          (p_busy),
    .enet_data_out (p_data_out),
    .enet_data_oe  (p_data_oe),
    .enet_data_in  (16'h0000),
    .enet_cmd      (p_cmd),
    .enet_cs_n     (p_cs_n),
    .enet_rd_n     (p_rd_n),
    .enet_wr_n     (p_wr_n)
  );

  initial clk50 = 1'b0;
  always #10 clk50 = ~clk50;

  task automatic step();
    @(posedge clk50);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req = '0; req_lock = '0; req_we = '0; req_data_only = '0;
    req_addr = '0; req_wdata = '0; enet_data_in = '0;
    p_req = '0; p_req_lock = '0; p_req_we = '0; p_req_data_only = '0;
    p_req_addr = '0; p_req_wdata = '0;
    step();
    step();
    reset = 1'b0;
    checks++; if (grant !== 3'b000) begin errors++; $display("FAIL reset_grant: got %b want 000", grant); end
    checks++; if (ack !== 3'b000) begin errors++; $display("FAIL reset_ack: got %b want 000", ack); end
    checks++; if (rdata !== 16'h0000) begin errors++; $display("FAIL reset_rdata: got %h want 0000", rdata); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (enet_data_out !== 16'h0000) begin errors++; $display("FAIL reset_dout: got %h want 0000", enet_data_out); end
    checks++; if (enet_data_oe !== 1'b0) begin errors++; $display("FAIL reset_oe: got %b want 0", enet_data_oe); end
    checks++; if (enet_cmd !== 1'b0) begin errors++; $display("FAIL reset_cmd: got %b want 0", enet_cmd); end
    checks++; if (enet_cs_n !== 1'b1) begin errors++; $display("FAIL reset_cs_n: got %b want 1", enet_cs_n); end
    checks++; if (enet_rd_n !== 1'b1) begin errors++; $display("FAIL reset_rd_n: got %b want 1", enet_rd_n); end
    checks++; if (enet_wr_n !== 1'b1) begin errors++; $display("FAIL reset_wr_n: got %b want 1", enet_wr_n); end
    checks++; if (p_cs_n !== 1'b1) begin errors++; $display("FAIL reset_p_cs_n: got %b want 1", p_cs_n); end
  endtask

  task automatic test_single_write();
    logic exp_wr;
    req_addr[7:0] = 8'h1F; req_wdata[15:0] = 16'h0000;
    req_we[0] = 1'b1; req_data_only[0] = 1'b0; req_lock[0] = 1'b0; req[0] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      exp_wr = (k == 2) || (k == 3) || (k == 7) || (k == 8);
      checks++; if (enet_wr_n !== !exp_wr) begin errors++; $display("FAIL wr_strobe k=%0d: got %b want %b", k, enet_wr_n, !exp_wr); end
      checks++; if (ack !== ((k == 11) ? 3'b001 : 3'b000)) begin errors++; $display("FAIL wr_ack k=%0d: got %b", k, ack); end
      if (k == 1) begin
        checks++; if (grant !== 3'b001 || busy !== 1'b1) begin errors++; $display("FAIL wr_grant: got %b/%b want 001/1", grant, busy); end
      end
      if (k == 2) begin
        checks++; if (enet_cmd !== 1'b0 || enet_data_out !== 16'h001F) begin errors++; $display("FAIL wr_index: got cmd=%b data=%h want 0/001f", enet_cmd, enet_data_out); end
      end
      if (k == 7) begin
        checks++; if (enet_cmd !== 1'b1 || enet_data_out !== 16'h0000) begin errors++; $display("FAIL wr_data: got cmd=%b data=%h want 1/0000", enet_cmd, enet_data_out); end
      end
      if (k == 11) req[0] = 1'b0;
      if (k == 12) begin
        checks++; if (busy !== 1'b0 || grant !== 3'b000) begin errors++; $display("FAIL wr_release: got busy=%b grant=%b", busy, grant); end
      end
    end
  endtask

  task automatic test_read();
    logic exp_oe, exp_rd, exp_wr;
    enet_data_in = 16'hDEAD;
    req_addr[15:8] = 8'h28; req_we[1] = 1'b0; req_data_only[1] = 1'b0; req_lock[1] = 1'b0;
    req[1] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      enet_data_in = (k == 7) ? 16'h1234 : ((k == 8) ? 16'h0A46 : 16'hDEAD);
      exp_oe = (k <= 5);
      exp_rd = (k == 7) || (k == 8);
      exp_wr = (k == 2) || (k == 3);
      checks++; if (enet_data_oe !== exp_oe) begin errors++; $display("FAIL rd_oe k=%0d: got %b want %b", k, enet_data_oe, exp_oe); end
      checks++; if (enet_rd_n !== !exp_rd) begin errors++; $display("FAIL rd_strobe k=%0d: got %b want %b", k, enet_rd_n, !exp_rd); end
      checks++; if (enet_wr_n !== !exp_wr) begin errors++; $display("FAIL rd_wr_n k=%0d: got %b want %b", k, enet_wr_n, !exp_wr); end
      if (k == 11) begin
        checks++; if (ack !== 3'b010) begin errors++; $display("FAIL rd_ack: got %b want 010", ack); end
        checks++; if (rdata !== 16'h0A46) begin errors++; $display("FAIL rd_data: got %h want 0a46", rdata); end
        req[1] = 1'b0;
      end
    end
  endtask

  task automatic test_contention();
    int order[4] = '{0, 1, 2, 0};
    int nack = 0;
    int cyc = 0;
    logic [2:0] prev_ack = 3'b000;
    logic [2:0] exp_ack;
    reset = 1'b1;
    step();
    reset = 1'b0;
    req_addr = 24'h121110; req_wdata = 48'h3333_2222_1111;
    req_we = 3'b111; req_data_only = 3'b000; req_lock = 3'b000; req = 3'b111;
    while (nack < 4 && cyc < 60) begin
      step();
      cyc++;
      checks++; if (!enet_rd_n && !enet_wr_n) begin errors++; $display("FAIL cont_overlap cyc=%0d: rd_n=%b wr_n=%b", cyc, enet_rd_n, enet_wr_n); end
      if (ack !== 3'b000) begin
        exp_ack = 3'b001 << order[nack];
        checks++; if (ack !== exp_ack) begin errors++; $display("FAIL cont_order n=%0d: got %b want %b", nack, ack, exp_ack); end
        checks++; if (prev_ack !== 3'b000) begin errors++; $display("FAIL cont_pulse n=%0d: prev ack %b want 000", nack, prev_ack); end
        checks++; if (cyc !== 11 + 12 * nack) begin errors++; $display("FAIL cont_time n=%0d: got %0d want %0d", nack, cyc, 11 + 12 * nack); end
        nack++;
        if (nack == 4) req = 3'b000;
      end
      prev_ack = ack;
    end
    checks++; if (nack != 4) begin errors++; $display("FAIL cont_timeout: got %0d acks want 4", nack); end
    step();
    checks++; if (ack !== 3'b000) begin errors++; $display("FAIL cont_ack_width: got %b want 000", ack); end
  endtask

  task automatic test_lock_burst();
    int nack = 0;
    int cyc = 1;
    int last = 0;
    req_addr[15:8] = 8'hF8; req_wdata[31:16] = 16'hAAAA;
    req_we[1] = 1'b1; req_data_only[1] = 1'b0; req_lock[1] = 1'b1; req[1] = 1'b1;
    step();
    checks++; if (grant !== 3'b010) begin errors++; $display("FAIL lock_first_grant: got %b want 010", grant); end
    req_addr[7:0] = 8'h05; req_we[0] = 1'b1; req_data_only[0] = 1'b0; req_lock[0] = 1'b0;
    req[0] = 1'b1;
    while (nack < 5 && cyc < 120) begin
      step();
      cyc++;
      checks++; if (grant[0] !== 1'b0) begin errors++; $display("FAIL lock_intrude cyc=%0d: grant %b", cyc, grant); end
      if (nack >= 1 && !enet_cs_n) begin
        checks++; if (enet_cmd !== 1'b1) begin errors++; $display("FAIL lock_no_index cyc=%0d: cmd %b want 1", cyc, enet_cmd); end
      end
      if (nack >= 1 && !enet_wr_n) begin
        checks++; if (enet_data_out !== 16'(nack) * 16'h1111) begin errors++; $display("FAIL lock_wdata n=%0d: got %h want %h", nack, enet_data_out, 16'(nack) * 16'h1111); end
      end
      if (ack[1]) begin
        if (nack == 0) begin
          checks++; if (cyc != 11) begin errors++; $display("FAIL lock_first_ack: got %0d want 11", cyc); end
        end else begin
          checks++; if (cyc - last != 6) begin errors++; $display("FAIL lock_spacing n=%0d: got %0d want 6", nack, cyc - last); end
        end
        last = cyc;
        nack++;
        if (nack < 5) begin
          req_data_only[1] = 1'b1;
          req_wdata[31:16] = 16'(nack) * 16'h1111;
        end else begin
          req_lock[1] = 1'b0;
          req[1] = 1'b0;
        end
      end
    end
    checks++; if (nack != 5) begin errors++; $display("FAIL lock_timeout: got %0d acks want 5", nack); end
    step();
    step();
    checks++; if (grant !== 3'b001) begin errors++; $display("FAIL lock_release_grant: got %b want 001", grant); end
    for (int w = 0; w < 15 && !ack[0]; w++) step();
    checks++; if (ack !== 3'b001) begin errors++; $display("FAIL lock_req0_ack: got %b want 001", ack); end
    req[0] = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    req_addr[23:16] = 8'h33; req_wdata[47:32] = 16'h5555;
    req_we[2] = 1'b1; req_data_only[2] = 1'b0; req_lock[2] = 1'b0; req[2] = 1'b1;
    step();
    step();
    checks++; if (enet_wr_n !== 1'b0 || grant !== 3'b100) begin errors++; $display("FAIL rst_pre: wr_n=%b grant=%b want 0/100", enet_wr_n, grant); end
    reset = 1'b1;
    req[2] = 1'b0;
    step();
    checks++; if (enet_wr_n !== 1'b1) begin errors++; $display("FAIL rst_wr_n: got %b want 1", enet_wr_n); end
    checks++; if (enet_cs_n !== 1'b1) begin errors++; $display("FAIL rst_cs_n: got %b want 1", enet_cs_n); end
    checks++; if (enet_data_oe !== 1'b0) begin errors++; $display("FAIL rst_oe: got %b want 0", enet_data_oe); end
    checks++; if (grant !== 3'b000 || busy !== 1'b0) begin errors++; $display("FAIL rst_grant: got %b/%b want 000/0", grant, busy); end
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      checks++; if (ack !== 3'b000) begin errors++; $display("FAIL rst_no_ack k=%0d: got %b", k, ack); end
      step();
    end
    req[2] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      checks++; if (ack !== ((k == 11) ? 3'b100 : 3'b000)) begin errors++; $display("FAIL rst_fresh_ack k=%0d: got %b", k, ack); end
      if (k == 11) req[2] = 1'b0;
    end
  endtask

  task automatic test_params();
    logic exp_wr;
    p_req_wdata[15:0] = 16'hBEEF; p_req_we[0] = 1'b1; p_req_data_only[0] = 1'b1;
    p_req_lock[0] = 1'b0; p_req[0] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      exp_wr = (k >= 3) && (k <= 5);
      checks++; if (p_wr_n !== !exp_wr) begin errors++; $display("FAIL par_strobe k=%0d: got %b want %b", k, p_wr_n, !exp_wr); end
      checks++; if (p_ack !== ((k == 7) ? 3'b001 : 3'b000)) begin errors++; $display("FAIL par_ack k=%0d: got %b", k, p_ack); end
      if (!p_cs_n) begin
        checks++; if (p_cmd !== 1'b1) begin errors++; $display("FAIL par_no_index k=%0d: cmd %b want 1", k, p_cmd); end
      end
      if (k == 3) begin
        checks++; if (p_data_out !== 16'hBEEF) begin errors++; $display("FAIL par_wdata: got %h want beef", p_data_out); end
      end
      if (k == 7) p_req[0] = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_read();
    test_contention();
    test_lock_burst();
    test_reset_mid();
    test_params();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
